// File: rtl/isa_pkg.sv
// Shared instruction-set definitions for the issue unit and the pipelined processor:
// opcodes, field positions, the NOP word and the issue FSM state type.
package isa_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_LOAD = 4'h3;

  localparam int OPC_LSB = 28;
  localparam int RD_LSB  = 24;
  localparam int RS1_LSB = 20;
  localparam int RS2_LSB = 16;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } issue_state_t;

  function automatic logic [3:0] field4(input logic [31:0] word, input int lsb);
    return word[lsb +: 4];
  endfunction

  function automatic logic op_writes_rd(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_LOAD);
  endfunction

  function automatic logic op_reads_rs2(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// Shift register of in-flight destination registers plus the read-after-write compare
// that decides whether the candidate instruction has to wait.
module issue_scoreboard
  import isa_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       flush,
  input  logic [3:0] rd,
  input  logic [3:0] rs1,
  input  logic [3:0] rs2,
  input  logic       reads_rs2,
  output logic       hazard,
  output logic       empty
);

  logic [DEPTH-1:0] valid_reg;
  logic [3:0]       rd_reg [DEPTH];
  logic [DEPTH-1:0] match;
  logic [DEPTH-1:0] kept;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_reg <= '0;
      for (int i = 0; i < DEPTH; i++) rd_reg[i] <= '0;
    end else if (flush) begin
      valid_reg <= '0;
    end else begin
      valid_reg[0] <= push;
      rd_reg[0]    <= rd;
      for (int i = 1; i < DEPTH; i++) begin
        valid_reg[i] <= valid_reg[i-1];
        rd_reg[i]    <= rd_reg[i-1];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      assign match[gi] = valid_reg[gi] &&
                         ((rd_reg[gi] == rs1) || (reads_rs2 && (rd_reg[gi] == rs2)));
      // The oldest entry retires on this edge, so it does not count towards "empty after shift".
      assign kept[gi]  = (gi < DEPTH - 1) ? valid_reg[gi] : 1'b0;
    end
  endgenerate

  assign hazard = |match;
  assign empty  = ~|kept;

endmodule

// File: rtl/instr_issue_unit.sv
// Program memory plus issue sequencer for the forwarding-less pipelined processor;
// inserts NOP bubbles until every register the next word reads has been written back.
module instr_issue_unit
  import isa_pkg::*;
#(
  parameter int ADDR_W     = 4,
  parameter int WB_LATENCY = 3,
  parameter int STALL_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data,
  input  logic              start,
  input  logic [ADDR_W:0]   prog_len,
  output logic [31:0]       instruction,
  output logic              issue_valid,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   pc,
  output logic [STALL_W-1:0] stall_count
);

  localparam int              DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W + 1)'(DEPTH);

  logic [31:0] mem [DEPTH];

  issue_state_t      state_reg, state_next;
  logic [ADDR_W:0]   pc_reg, pc_next;
  logic [ADDR_W:0]   len_reg, len_next;
  logic [STALL_W-1:0] stall_reg, stall_next;
  logic [31:0]       instr_reg, instr_next;
  logic              valid_reg, valid_next;

  logic [31:0] cand;
  logic [3:0]  cand_op;
  logic        cand_writes;
  logic        cand_rs2;
  logic        sb_hazard;
  logic        sb_empty;
  logic        hazard;
  logic        push;
  logic        flush;

  always_ff @(posedge clk) begin
    if (load_en && !busy) mem[load_addr] <= load_data;
  end

  assign cand        = mem[pc_reg[ADDR_W-1:0]];
  assign cand_op     = field4(cand, OPC_LSB);
  assign cand_writes = op_writes_rd(cand_op);
  assign cand_rs2    = op_reads_rs2(cand_op);
  // Every register-writing opcode also reads rs1; anything else reads nothing.
  assign hazard      = sb_hazard && cand_writes;
  assign flush       = (state_reg == ST_IDLE) || (state_reg == ST_DONE);

  issue_scoreboard #(.DEPTH(WB_LATENCY)) u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .flush     (flush),
    .rd        (field4(cand, RD_LSB)),
    .rs1       (field4(cand, RS1_LSB)),
    .rs2       (field4(cand, RS2_LSB)),
    .reads_rs2 (cand_rs2),
    .hazard    (sb_hazard),
    .empty     (sb_empty)
  );

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    len_next   = len_reg;
    stall_next = stall_reg;
    instr_next = NOP_WORD;
    valid_next = 1'b0;
    push       = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        if (start) begin
          if (prog_len == '0) begin
            state_next = ST_DONE;
          end else begin
            pc_next    = '0;
            stall_next = '0;
            len_next   = (prog_len > MAX_LEN) ? MAX_LEN : prog_len;
            state_next = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (hazard) begin
          if (stall_reg != {STALL_W{1'b1}}) stall_next = stall_reg + 1'b1;
        end else begin
          // Undefined opcodes still consume their slot but go out as a NOP.
          instr_next = (cand_op <= OP_LOAD) ? cand : NOP_WORD;
          valid_next = 1'b1;
          push       = cand_writes;
          pc_next    = pc_reg + 1'b1;
          if (pc_reg == len_reg - 1'b1) state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (sb_empty) state_next = ST_DONE;
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      pc_reg    <= '0;
      len_reg   <= '0;
      stall_reg <= '0;
      instr_reg <= NOP_WORD;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      len_reg   <= len_next;
      stall_reg <= stall_next;
      instr_reg <= instr_next;
      valid_reg <= valid_next;
    end
  end

  assign instruction = instr_reg;
  assign issue_valid = valid_reg;
  assign busy        = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);
  assign done        = (state_reg == ST_DONE);
  assign pc          = pc_reg;
  assign stall_count = stall_reg;

endmodule

// File: tb/tb_instr_issue_unit.sv
// Scoreboard bench for instr_issue_unit: expected per-cycle issue stream is queued at start
// and popped every cycle; a small register-file model checks the processor-visible results.
module tb_instr_issue_unit;

  localparam logic [31:0] W_ADD1   = 32'h1123_0000; // ADD R1=R2+R3
  localparam logic [31:0] W_SUB4   = 32'h2456_0000; // SUB R4=R5-R6
  localparam logic [31:0] W_LOAD7  = 32'h3780_0000; // LOAD R7=R8
  localparam logic [31:0] W_SUB4D  = 32'h2416_0000; // SUB R4=R1-R6
  localparam logic [31:0] W_ADD9A  = 32'h1937_0000; // ADD R9=R3+R7
  localparam logic [31:0] W_ADD9B  = 32'h1973_0000; // ADD R9=R7+R3

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load_en = 1'b0;
  logic [3:0]  load_addr = '0;
  logic [31:0] load_data = '0;
  logic        start = 1'b0;
  logic [4:0]  prog_len = '0;
  logic [31:0] instruction;
  logic        issue_valid;
  logic        busy;
  logic        done;
  logic [4:0]  pc;
  logic [15:0] stall_count;

  int    tests_run = 0;
  int    tests_failed = 0;
  int    seq_idx = 0;
  string cur_test = "none";

  typedef struct {
    logic [31:0] instr;
    logic        valid;
    logic        busy;
    logic        done;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;

  logic [31:0] regs [16];
  logic        pv   [3];
  logic [3:0]  prd  [3];
  logic [31:0] pval [3];
  logic [3:0]  m_op;

  instr_issue_unit #(.ADDR_W(4), .WB_LATENCY(3), .STALL_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .start       (start),
    .prog_len    (prog_len),
    .instruction (instruction),
    .issue_valid (issue_valid),
    .busy        (busy),
    .done        (done),
    .pc          (pc),
    .stall_count (stall_count)
  );

  always #5 clk = ~clk;

  // Per-cycle monitor: processor model update, then scoreboard pop/compare.
  always @(posedge clk) begin
    #1;
    if (pv[2]) regs[prd[2]] = pval[2];
    for (int i = 2; i > 0; i--) begin
      pv[i]   = pv[i-1];
      prd[i]  = prd[i-1];
      pval[i] = pval[i-1];
    end
    pv[0] = 1'b0;
    m_op = instruction[31:28];
    if (issue_valid === 1'b1 && (m_op == 4'h1 || m_op == 4'h2 || m_op == 4'h3)) begin
      pv[0]  = 1'b1;
      prd[0] = instruction[27:24];
      case (m_op)
        4'h1:    pval[0] = regs[instruction[23:20]] + regs[instruction[19:16]];
        4'h2:    pval[0] = regs[instruction[23:20]] - regs[instruction[19:16]];
        default: pval[0] = regs[instruction[23:20]];
      endcase
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests_run++;
      if ({instruction, issue_valid, busy, done} !== {e.instr, e.valid, e.busy, e.done}) begin
        tests_failed++;
        $display("FAIL %s[%0d]: got instr=%h valid=%b busy=%b done=%b, expected instr=%h valid=%b busy=%b done=%b",
                 cur_test, seq_idx, instruction, issue_valid, busy, done, e.instr, e.valid, e.busy, e.done);
      end else begin
        $display("[TB] %s[%0d] instr=%h valid=%b busy=%b done=%b ok",
                 cur_test, seq_idx, instruction, issue_valid, busy, done);
      end
      seq_idx++;
    end
  end

  task automatic push_exp(input logic [31:0] i, input logic v, input logic b, input logic d);
    exp_t x;
    x.instr = i; x.valid = v; x.busy = b; x.done = d;
    exp_q.push_back(x);
  endtask

  task automatic push_idle(input int n, input logic b);
    for (int k = 0; k < n; k++) push_exp(32'h0, 1'b0, b, 1'b0);
  endtask

  task automatic load_word(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic preload_regs();
    for (int i = 0; i < 16; i++) regs[i] = 32'd0;
    for (int i = 0; i < 3; i++) pv[i] = 1'b0;
    regs[2] = 32'd10; regs[3] = 32'd5; regs[5] = 32'd20; regs[6] = 32'd4; regs[8] = 32'd42;
  endtask

  task automatic begin_start(input string name, input logic [4:0] len);
    @(negedge clk);
    cur_test = name;
    seq_idx = 0;
    prog_len = len;
    start = 1'b1;
  endtask

  task automatic end_start();
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 60 && exp_q.size() > 0; c++) @(negedge clk);
    if (exp_q.size() > 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL %s timeout: %0d entries left, required 0", cur_test, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_reg(input string name, input int r, input logic [31:0] want);
    tests_run++;
    if (regs[r] !== want) begin
      tests_failed++;
      $display("FAIL %s R%0d: got %0d, required %0d", name, r, regs[r], want);
    end else begin
      $display("[TB] %s R%0d=%0d ok", name, r, regs[r]);
    end
  endtask

  task automatic push_indep_stream();
    push_exp(32'h0, 1'b0, 1'b1, 1'b0);
    push_exp(W_ADD1, 1'b1, 1'b1, 1'b0);
    push_exp(W_SUB4, 1'b1, 1'b1, 1'b0);
    push_exp(W_LOAD7, 1'b1, 1'b1, 1'b0);
    push_idle(2, 1'b1);
    push_exp(32'h0, 1'b0, 1'b0, 1'b1);
    push_idle(1, 1'b0);
  endtask

  task automatic push_dep_stream(input logic [31:0] first, input logic [31:0] second);
    push_exp(32'h0, 1'b0, 1'b1, 1'b0);
    push_exp(first, 1'b1, 1'b1, 1'b0);
    push_idle(3, 1'b1);
    push_exp(second, 1'b1, 1'b1, 1'b0);
    push_idle(2, 1'b1);
    push_exp(32'h0, 1'b0, 1'b0, 1'b1);
    push_idle(1, 1'b0);
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    #1;
    tests_run++;
    if ({instruction, issue_valid, busy, done, pc, stall_count} !== '0) begin
      tests_failed++;
      $display("FAIL reset_state: got instr=%h valid=%b busy=%b done=%b pc=%0d stall=%0d, required all zero",
               instruction, issue_valid, busy, done, pc, stall_count);
    end else begin
      $display("[TB] reset_state ok");
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_independent();
    load_word(4'd0, W_ADD1);
    load_word(4'd1, W_SUB4);
    load_word(4'd2, W_LOAD7);
    preload_regs();
    begin_start("independent", 5'd3);
    push_indep_stream();
    end_start();
    wait_drain();
    tests_run++;
    if (stall_count !== 16'd0 || pc !== 5'd3) begin
      tests_failed++;
      $display("FAIL independent counters: got stall=%0d pc=%0d, required stall=0 pc=3", stall_count, pc);
    end
    check_reg("independent", 1, 32'd15);
    check_reg("independent", 4, 32'd16);
    check_reg("independent", 7, 32'd42);
  endtask

  task automatic test_raw_dependency();
    load_word(4'd0, W_ADD1);
    load_word(4'd1, W_SUB4D);
    preload_regs();
    begin_start("raw_dep", 5'd2);
    push_dep_stream(W_ADD1, W_SUB4D);
    end_start();
    wait_drain();
    tests_run++;
    if (stall_count !== 16'd3) begin
      tests_failed++;
      $display("FAIL raw_dep stall_count: got %0d, required 3", stall_count);
    end
    check_reg("raw_dep", 4, 32'd11);
  endtask

  task automatic test_rs2_and_nop();
    load_word(4'd0, W_LOAD7);
    load_word(4'd1, W_ADD9A);
    preload_regs();
    begin_start("rs2_dep", 5'd2);
    push_dep_stream(W_LOAD7, W_ADD9A);
    end_start();
    wait_drain();
    tests_run++;
    if (stall_count !== 16'd3) begin
      tests_failed++;
      $display("FAIL rs2_dep stall_count: got %0d, required 3", stall_count);
    end
    check_reg("rs2_dep", 9, 32'd47);

    load_word(4'd1, 32'h0);
    load_word(4'd2, W_ADD9B);
    preload_regs();
    begin_start("nop_slot", 5'd3);
    push_exp(32'h0, 1'b0, 1'b1, 1'b0);
    push_exp(W_LOAD7, 1'b1, 1'b1, 1'b0);
    push_exp(32'h0, 1'b1, 1'b1, 1'b0);
    push_idle(2, 1'b1);
    push_exp(W_ADD9B, 1'b1, 1'b1, 1'b0);
    push_idle(2, 1'b1);
    push_exp(32'h0, 1'b0, 1'b0, 1'b1);
    push_idle(1, 1'b0);
    end_start();
    wait_drain();
    tests_run++;
    if (stall_count !== 16'd2 || pc !== 5'd3) begin
      tests_failed++;
      $display("FAIL nop_slot counters: got stall=%0d pc=%0d, required stall=2 pc=3", stall_count, pc);
    end
    check_reg("nop_slot", 9, 32'd47);
  endtask

  task automatic test_zero_len();
    begin_start("zero_len", 5'd0);
    push_exp(32'h0, 1'b0, 1'b0, 1'b1);
    push_idle(2, 1'b0);
    end_start();
    wait_drain();
  endtask

  task automatic test_reset_mid_run();
    load_word(4'd0, W_ADD1);
    load_word(4'd1, W_SUB4);
    load_word(4'd2, W_LOAD7);
    preload_regs();
    begin_start("mid_reset", 5'd3);
    end_start();
    @(negedge clk);
    @(negedge clk);
    tests_run++;
    if (instruction !== W_SUB4 || pc !== 5'd2 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_reset pre: got instr=%h pc=%0d busy=%b, required instr=%h pc=2 busy=1",
               instruction, pc, busy, W_SUB4);
    end
    #1 reset = 1'b0;
    #1;
    tests_run++;
    if (instruction !== 32'h0 || issue_valid !== 1'b0 || busy !== 1'b0 || pc !== 5'd0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset async: got instr=%h valid=%b busy=%b pc=%0d done=%b, required all zero",
               instruction, issue_valid, busy, pc, done);
    end else begin
      $display("[TB] mid_reset async clear ok");
    end
    @(negedge clk);
    reset = 1'b1;
    preload_regs();
    begin_start("restart", 5'd3);
    push_indep_stream();
    end_start();
    wait_drain();
    check_reg("restart", 1, 32'd15);
    check_reg("restart", 7, 32'd42);
  endtask

  task automatic test_busy_ignore();
    load_word(4'd0, W_ADD1);
    load_word(4'd1, W_SUB4D);
    preload_regs();
    begin_start("busy_ignore", 5'd2);
    push_dep_stream(W_ADD1, W_SUB4D);
    end_start();
    load_en = 1'b1; load_addr = 4'd0; load_data = 32'hFFFF_FFFF;
    start = 1'b1; prog_len = 5'd1;
    @(negedge clk);
    load_en = 1'b0; start = 1'b0;
    tests_run++;
    if (pc !== 5'd1) begin
      tests_failed++;
      $display("FAIL busy_ignore pc: got %0d, required 1", pc);
    end
    wait_drain();
    preload_regs();
    begin_start("rerun", 5'd2);
    push_dep_stream(W_ADD1, W_SUB4D);
    end_start();
    wait_drain();
    tests_run++;
    if (stall_count !== 16'd3) begin
      tests_failed++;
      $display("FAIL rerun stall_count: got %0d, required 3", stall_count);
    end
    check_reg("rerun", 4, 32'd11);
  endtask

  initial begin
    preload_regs();
    test_reset();
    test_independent();
    test_raw_dependency();
    test_rs2_and_nop();
    test_zero_len();
    test_reset_mid_run();
    test_busy_ignore();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
